// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of a shared combinational ALU, with a registered response.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
`timescale 1ns/1ps

module alu_share_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_x,
  output logic        rsp_zero,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_x,
  input  logic        alu_zero
);

  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        id_q, id_d;
  logic [31:0] rsp_x_q, rsp_x_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        grant0, grant1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // ptr_q holds the last granted requester; on contention the other one wins
  always_comb begin
    grant0 = req0_valid && (!req1_valid || ptr_q);
    grant1 = req1_valid && (!req0_valid || !ptr_q);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (req0_ready || req1_ready) ptr_d = req1_ready;
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  // rst_n gating keeps ready low while reset is held even though IDLE is already the reset state
  assign req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_x_d    = rsp_x_q;
    rsp_zero_d = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          op_d    = req0_op;
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = 1'b0;
          state_d = EXEC;
        end else if (req1_ready) begin
          op_d    = req1_op;
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_x_d    = alu_x;
        rsp_zero_d = (op_q == OP_SUB) ? alu_zero : 1'b0;
        state_d    = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 3'b000;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      id_q       <= 1'b0;
      rsp_x_q    <= 32'd0;
      rsp_zero_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q      <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_x_q    <= rsp_x_d;
      rsp_zero_q <= rsp_zero_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_zero  = rsp_zero_q;

endmodule
